mips_alu_seq_ctrl: RTL and testbench
====================================

# mips_alu_seq_ctrl

Multi-cycle issue/control sequencer that drives the MIPS datapath ALU. It accepts one instruction word per valid/ready handshake and decodes it into ALU controls: op, sign control and operand selects. It samples the ALU's zero/overflow flags and emits a one-cycle write-back/branch/trap result. It sits between instruction fetch and the register-file/PC update logic.

## Interface
- `TRAP_EN`, default 1: when 1, signed-add overflow raises `trap`. When 0, overflow is ignored.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `instr_valid`, input, 1: `instr` is valid.
- `instr_ready`, output, 1: block can accept an instruction. High only in IDLE.
- `instr`, input, 32: MIPS instruction word. Captured on accept.
- `alu_op`, output, 4: ALU operation code.
- `sign_ctrl`, output, 1: 1 = signed compare, 0 = unsigned compare.
- `alu_src_a`, output, 1: A operand select. 0 = rs, 1 = zero-extended shamt.
- `alu_src_b`, output, 2: B operand select. 00 = rt, 01 = sign-extended imm16, 10 = zero-extended imm16, 11 = constant 0.
- `alu_zero`, input, 1: ALU zero/condition flag.
- `alu_overflow`, input, 1: ALU add carry/overflow flag.
- `wb_valid`, output, 1: one-cycle result strobe.
- `reg_write`, output, 1: write ALU result to `wb_reg`. Qualified by `wb_valid`.
- `wb_reg`, output, 5: destination register. R-type uses rd = instr[15:11]; I-type uses rt = instr[20:16].
- `branch_taken`, output, 1: branch condition met. Qualified by `wb_valid`.
- `trap`, output, 1: overflow or illegal instruction. Qualified by `wb_valid`.

## Operation
- ALU op encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR
  - 0100 XOR, 0101 NAND, 0110 NOR, 0111 XNOR
  - 1000 SLE (zero=1 when A≤B, signed)
  - 1001 SRA (B>>>A)
  - 1010 SLT (signedness per `sign_ctrl`)
  - 1011 SGT (zero=1 when A>B, signed)
  - 1100 SLL (B<<A), 1101 SRL (B>>A)
  - 1110 NEQ (zero=1 when A≠B)
- R-type decode (opcode 0), by funct:
  - 0x20 ADD and 0x21 ADDU → 0000
  - 0x22 SUB and 0x23 SUBU → 0001
  - 0x24 → 0010, 0x25 → 0011, 0x26 → 0100, 0x27 → 0110
  - 0x2A SLT → 1010 with sign 1; 0x2B SLTU → 1010 with sign 0
  - 0x00 → 1100, 0x02 → 1101, 0x03 → 1001; shifts use `alu_src_a`=1
  - All R-type use `alu_src_b`=00.
- I-type decode, by opcode:
  - 0x08 ADDI and 0x09 ADDIU → 0000, src_b 01
  - 0x0C → 0010, 0x0D → 0011, 0x0E → 0100; all src_b 10
  - 0x0A SLTI → 1010 with sign 1; 0x0B SLTIU → 1010 with sign 0; both src_b 01 (sign-extended)
- Branch decode; all have `reg_write`=0:
  - BEQ 0x04: op 0001, src_b 00, taken = zero.
  - BNE 0x05: op 1110, src_b 00, taken = zero.
  - BLEZ 0x06: op 1000, src_b 11, taken = zero.
  - BGTZ 0x07: op 1011, src_b 11, taken = zero.
- Trap rules:
  - Only ADD and ADDI trap on `alu_overflow`=1 (when TRAP_EN=1).
  - ADDU, ADDIU, SUB and SUBU never trap.
  - A trapping instruction has `reg_write`=0.
- Any other opcode/funct is illegal: `trap`=1, `reg_write`=0, `branch_taken`=0.
- FSM states: IDLE → DECODE → EXEC → WB → IDLE.
  - IDLE: `instr_ready`=1. An accept (`instr_valid`&`instr_ready`) captures `instr` → DECODE.
  - DECODE: registers the control bundle; ALU controls become stable at the exit of DECODE. Illegal instructions skip EXEC → WB.
  - EXEC: ALU controls held. Flags sampled at the end of the cycle.
  - WB: `wb_valid`=1 for exactly one cycle with the registered results → IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, `instr_ready`=0 during reset. `instr_ready`=1 on the first cycle after release.
- Accept edge = cycle 0. DECODE in cycle 1, EXEC in cycle 2, `wb_valid` in cycle 3.
- Throughput: one instruction per 4 cycles. An illegal instruction takes 3 cycles (`wb_valid` in cycle 2).
- `alu_op`, `sign_ctrl` and the src selects are registered. They are held from DECODE through WB and hold their last value in IDLE.
- `alu_zero`/`alu_overflow` are ignored outside EXEC.
- `instr_valid` while not ready: ignored, no capture. The instruction is accepted once back in IDLE if still valid.
- `rst_n` low in any state: immediate return to IDLE, outputs 0, any in-flight instruction is dropped and produces no `wb_valid`.

## Structure
- Package `mips_ctrl_pkg` holds:
  - ALU op localparams
  - opcode/funct constants
  - src_a/src_b encodings
  - FSM state enum
  - control-bundle struct: op, sign, src_a, src_b, reg_write, is_branch, traps_ovf, illegal, dst_sel.
- Sub-module `mips_alu_decode`: combinational instr → control bundle. The top level contains the FSM and registers.

## Test plan
- ADD rd=3 (funct 0x20), ALU overflow=0 → `alu_op`=0000, src_b=00, cycle-3 `wb_valid` with `reg_write`=1, `wb_reg`=3, `trap`=0.
- ADDI rt=5, alu_overflow=1 in EXEC → `trap`=1, `reg_write`=0. Repeat with ADDIU → `trap`=0, `reg_write`=1.
- BNE with alu_zero=1, then BLEZ with alu_zero=0 → BNE: op 1110, `branch_taken`=1, `reg_write`=0. BLEZ: op 1000, src_b 11, `branch_taken`=0.
- SRA funct 0x03, shamt=4 → op 1001, `alu_src_a`=1, src_b 00; SLTIU → op 1010, `sign_ctrl`=0, src_b 01.
- Opcode 0x3F → `wb_valid` in cycle 2 with `trap`=1; `instr_ready` high again in cycle 3.
- `instr_valid` held high continuously → accepts spaced exactly 4 cycles apart. Assert `rst_n`=0 during EXEC → outputs 0 immediately, no `wb_valid`, `instr_ready`=1 one cycle after release.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS ALU issue/control sequencer.
// Holds the ALU op encodings, instruction opcode/funct constants,
// operand-select encodings, the sequencer state enum and the decoded
// control bundle passed from the decoder to the sequencer.
package mips_ctrl_pkg;

    // ALU operation codes driven on alu_op
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_NAND = 4'b0101;
    localparam logic [3:0] ALU_NOR  = 4'b0110;
    localparam logic [3:0] ALU_XNOR = 4'b0111;
    localparam logic [3:0] ALU_SLE  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_SLT  = 4'b1010;
    localparam logic [3:0] ALU_SGT  = 4'b1011;
    localparam logic [3:0] ALU_SLL  = 4'b1100;
    localparam logic [3:0] ALU_SRL  = 4'b1101;
    localparam logic [3:0] ALU_NEQ  = 4'b1110;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_BLEZ  = 6'h06;
    localparam logic [5:0] OPC_BGTZ  = 6'h07;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_SLTIU = 6'h0B;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Operand selects
    localparam logic       SRC_A_RS    = 1'b0;
    localparam logic       SRC_A_SHAMT = 1'b1;
    localparam logic [1:0] SRC_B_RT    = 2'b00;
    localparam logic [1:0] SRC_B_SIMM  = 2'b01;
    localparam logic [1:0] SRC_B_ZIMM  = 2'b10;
    localparam logic [1:0] SRC_B_ZERO  = 2'b11;

    // Destination register field select
    localparam logic DST_RD = 1'b0;
    localparam logic DST_RT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_e;

    typedef struct packed {
        logic [3:0] op;
        logic       sign;
        logic       src_a;
        logic [1:0] src_b;
        logic       reg_write;
        logic       is_branch;
        logic       traps_ovf;
        logic       illegal;
        logic       dst_sel;
    } ctrl_t;

endpackage

// File: rtl/mips_alu_decode.sv
// Combinational instruction decoder: opcode/funct -> ALU control bundle.
// Ports:
//   opcode - instr[31:26]
//   funct  - instr[5:0] (only meaningful for R-type)
//   ctrl   - decoded control bundle; unknown encodings set ctrl.illegal
module mips_alu_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (opcode)
            OPC_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.dst_sel   = DST_RD;
                ctrl.src_b     = SRC_B_RT;
                case (funct)
                    FN_ADD: begin
                        ctrl.op        = ALU_ADD;
                        ctrl.traps_ovf = 1'b1;
                    end
                    FN_ADDU:         ctrl.op = ALU_ADD;
                    FN_SUB, FN_SUBU: ctrl.op = ALU_SUB;
                    FN_AND:          ctrl.op = ALU_AND;
                    FN_OR:           ctrl.op = ALU_OR;
                    FN_XOR:          ctrl.op = ALU_XOR;
                    FN_NOR:          ctrl.op = ALU_NOR;
                    FN_SLT: begin
                        ctrl.op   = ALU_SLT;
                        ctrl.sign = 1'b1;
                    end
                    FN_SLTU:         ctrl.op = ALU_SLT;
                    FN_SLL: begin
                        ctrl.op    = ALU_SLL;
                        ctrl.src_a = SRC_A_SHAMT;
                    end
                    FN_SRL: begin
                        ctrl.op    = ALU_SRL;
                        ctrl.src_a = SRC_A_SHAMT;
                    end
                    FN_SRA: begin
                        ctrl.op    = ALU_SRA;
                        ctrl.src_a = SRC_A_SHAMT;
                    end
                    default:         ctrl.illegal = 1'b1;
                endcase
            end
            OPC_BEQ: begin
                ctrl.op        = ALU_SUB;
                ctrl.src_b     = SRC_B_RT;
                ctrl.is_branch = 1'b1;
                ctrl.dst_sel   = DST_RT;
            end
            OPC_BNE: begin
                ctrl.op        = ALU_NEQ;
                ctrl.src_b     = SRC_B_RT;
                ctrl.is_branch = 1'b1;
                ctrl.dst_sel   = DST_RT;
            end
            OPC_BLEZ: begin
                ctrl.op        = ALU_SLE;
                ctrl.src_b     = SRC_B_ZERO;
                ctrl.is_branch = 1'b1;
                ctrl.dst_sel   = DST_RT;
            end
            OPC_BGTZ: begin
                ctrl.op        = ALU_SGT;
                ctrl.src_b     = SRC_B_ZERO;
                ctrl.is_branch = 1'b1;
                ctrl.dst_sel   = DST_RT;
            end
            OPC_ADDI, OPC_ADDIU: begin
                ctrl.op        = ALU_ADD;
                ctrl.src_b     = SRC_B_SIMM;
                ctrl.reg_write = 1'b1;
                ctrl.dst_sel   = DST_RT;
                ctrl.traps_ovf = (opcode == OPC_ADDI);
            end
            OPC_SLTI, OPC_SLTIU: begin
                ctrl.op        = ALU_SLT;
                ctrl.sign      = (opcode == OPC_SLTI);
                ctrl.src_b     = SRC_B_SIMM;
                ctrl.reg_write = 1'b1;
                ctrl.dst_sel   = DST_RT;
            end
            OPC_ANDI, OPC_ORI, OPC_XORI: begin
                ctrl.op        = (opcode == OPC_ANDI) ? ALU_AND :
                                 (opcode == OPC_ORI)  ? ALU_OR  : ALU_XOR;
                ctrl.src_b     = SRC_B_ZIMM;
                ctrl.reg_write = 1'b1;
                ctrl.dst_sel   = DST_RT;
            end
            default: ctrl.illegal = 1'b1;
        endcase

        if (ctrl.illegal) begin
            ctrl.reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/mips_alu_seq_ctrl.sv
// Multi-cycle issue/control sequencer for the MIPS datapath ALU.
// Accepts one instruction per valid/ready handshake, registers the decoded
// ALU controls, samples the ALU flags during EXEC and emits a one-cycle
// write-back / branch / trap result.
// Ports:
//   clk, rst_n              - clock, async active-low reset
//   instr_valid/instr_ready - instruction handshake (ready only in IDLE)
//   instr                   - instruction word, captured on accept
//   alu_op, sign_ctrl,
//   alu_src_a, alu_src_b    - registered ALU controls, held DECODE..IDLE
//   alu_zero, alu_overflow  - ALU flags, sampled at the end of EXEC only
//   wb_valid                - one-cycle result strobe
//   reg_write, wb_reg,
//   branch_taken, trap      - result fields qualified by wb_valid
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | ready for an instruction; controls hold their last value
// ST_DECODE | captured word decoded; control bundle registered at exit
// ST_EXEC   | controls drive the ALU; flags sampled at exit
// ST_WB     | wb_valid high for this single cycle
module mips_alu_seq_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter logic TRAP_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [3:0]  alu_op,
    output logic        sign_ctrl,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    output logic        wb_valid,
    output logic        reg_write,
    output logic [4:0]  wb_reg,
    output logic        branch_taken,
    output logic        trap
);

    state_e     state_q,  state_d;
    logic       ready_q,  ready_d;
    logic [5:0] opcode_q, opcode_d;
    logic [5:0] funct_q,  funct_d;
    logic [4:0] rt_q,     rt_d;
    logic [4:0] rd_q,     rd_d;
    ctrl_t      ctrl_q,   ctrl_d;
    logic       wb_valid_q,  wb_valid_d;
    logic       reg_write_q, reg_write_d;
    logic [4:0] wb_reg_q,    wb_reg_d;
    logic       branch_q,    branch_d;
    logic       trap_q,      trap_d;

    ctrl_t      dec_ctrl;
    logic       ovf_trap;

    // rs and shamt feed the datapath directly, never the sequencer; the
    // registered illegal flag is consumed at decode time instead.
    logic       unused_bits;
    assign unused_bits = ^{instr[25:21], instr[10:6], ctrl_q.illegal};

    mips_alu_decode u_decode (
        .opcode (opcode_q),
        .funct  (funct_q),
        .ctrl   (dec_ctrl)
    );

    assign ovf_trap = ctrl_q.traps_ovf & TRAP_EN & alu_overflow;

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        funct_d     = funct_q;
        rt_d        = rt_q;
        rd_d        = rd_q;
        ctrl_d      = ctrl_q;
        wb_valid_d  = 1'b0;
        reg_write_d = 1'b0;
        branch_d    = 1'b0;
        trap_d      = 1'b0;
        wb_reg_d    = wb_reg_q;

        case (state_q)
            ST_IDLE: begin
                // ready_q gates the accept so nothing is taken on the first
                // edge after reset release, while instr_ready is still low.
                if (instr_valid && ready_q) begin
                    opcode_d = instr[31:26];
                    funct_d  = instr[5:0];
                    rt_d     = instr[20:16];
                    rd_d     = instr[15:11];
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                ctrl_d = dec_ctrl;
                if (dec_ctrl.illegal) begin
                    wb_valid_d = 1'b1;
                    trap_d     = 1'b1;
                    state_d    = ST_WB;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                wb_valid_d  = 1'b1;
                trap_d      = ovf_trap;
                reg_write_d = ctrl_q.reg_write & ~ovf_trap;
                branch_d    = ctrl_q.is_branch & alu_zero;
                wb_reg_d    = (ctrl_q.dst_sel == DST_RT) ? rt_q : rd_q;
                state_d     = ST_WB;
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            opcode_q    <= '0;
            funct_q     <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            ctrl_q      <= '0;
            wb_valid_q  <= 1'b0;
            reg_write_q <= 1'b0;
            wb_reg_q    <= '0;
            branch_q    <= 1'b0;
            trap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            opcode_q    <= opcode_d;
            funct_q     <= funct_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            ctrl_q      <= ctrl_d;
            wb_valid_q  <= wb_valid_d;
            reg_write_q <= reg_write_d;
            wb_reg_q    <= wb_reg_d;
            branch_q    <= branch_d;
            trap_q      <= trap_d;
        end
    end

    assign instr_ready  = ready_q;
    assign alu_op       = ctrl_q.op;
    assign sign_ctrl    = ctrl_q.sign;
    assign alu_src_a    = ctrl_q.src_a;
    assign alu_src_b    = ctrl_q.src_b;
    assign wb_valid     = wb_valid_q;
    assign reg_write    = reg_write_q;
    assign wb_reg       = wb_reg_q;
    assign branch_taken = branch_q;
    assign trap         = trap_q;

endmodule

// File: tb/tb_mips_alu_seq_ctrl.sv
module tb_mips_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [3:0]  alu_op;
    logic        sign_ctrl;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        alu_zero;
    logic        alu_overflow;
    logic        wb_valid;
    logic        reg_write;
    logic [4:0]  wb_reg;
    logic        branch_taken;
    logic        trap;

    always #5 clk = ~clk;

    mips_alu_seq_ctrl #(.TRAP_EN(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .alu_op       (alu_op),
        .sign_ctrl    (sign_ctrl),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .wb_valid     (wb_valid),
        .reg_write    (reg_write),
        .wb_reg       (wb_reg),
        .branch_taken (branch_taken),
        .trap         (trap)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference tables: -1 marks an illegal encoding.
    int r_op   [64];   // by funct, opcode 0
    int i_op   [64];   // by opcode
    int i_srcb [64];   // by opcode
    int legal_fn  [13] = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23,
                           6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    int legal_opc [11] = '{4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14};

    typedef struct {
        bit legal;
        int op;
        bit chk_sgn;
        bit sgn;
        bit srca;
        int srcb;
        bit wr;
        bit br;
        bit trp;
        int dst;
    } exp_t;

    function automatic exp_t model(input logic [31:0] ins);
        exp_t e;
        int opc = int'(ins[31:26]);
        int fn  = int'(ins[5:0]);
        if (opc == 0) begin
            e.legal   = (r_op[fn] >= 0);
            e.op      = r_op[fn];
            e.srca    = (fn == 0) || (fn == 2) || (fn == 3);
            e.srcb    = 0;
            e.br      = 0;
            e.wr      = 1;
            e.dst     = int'(ins[15:11]);
            e.trp     = (fn == 32);
            e.chk_sgn = (fn == 42) || (fn == 43);
            e.sgn     = (fn == 42);
        end else begin
            e.legal   = (i_op[opc] >= 0);
            e.op      = i_op[opc];
            e.srca    = 0;
            e.srcb    = i_srcb[opc];
            e.br      = (opc >= 4) && (opc <= 7);
            e.wr      = !e.br;
            e.dst     = int'(ins[20:16]);
            e.trp     = (opc == 8);
            e.chk_sgn = (opc == 10) || (opc == 11);
            e.sgn     = (opc == 10);
        end
        return e;
    endfunction

    // Runs one instruction through the handshake starting at a negedge.
    task automatic run_instr(input logic [31:0] ins, input logic z, input logic ov, input string tag);
        exp_t e;
        int   waited;
        bit   exp_trap;
        e = model(ins);
        waited = 0;
        while (!instr_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_ready"}, instr_ready, 1);
        instr        = ins;
        instr_valid  = 1'b1;
        alu_zero     = 1'($urandom);
        alu_overflow = 1'($urandom);
        @(negedge clk);                       // cycle 1: DECODE
        instr_valid = 1'b0;
        instr       = $urandom;
        check({tag, "_dec_ready"}, instr_ready, 0);
        check({tag, "_dec_wbv"}, wb_valid, 0);
        if (!e.legal) begin
            @(negedge clk);                   // cycle 2: WB
            check({tag, "_ill_wbv"}, wb_valid, 1);
            check({tag, "_ill_trap"}, trap, 1);
            check({tag, "_ill_wr"}, reg_write, 0);
            check({tag, "_ill_br"}, branch_taken, 0);
            @(negedge clk);                   // cycle 3: IDLE
            check({tag, "_ill_ready"}, instr_ready, 1);
            check({tag, "_ill_wbv_off"}, wb_valid, 0);
        end else begin
            @(negedge clk);                   // cycle 2: EXEC
            check({tag, "_op"}, alu_op, e.op);
            check({tag, "_srca"}, alu_src_a, e.srca);
            check({tag, "_srcb"}, alu_src_b, e.srcb);
            if (e.chk_sgn) check({tag, "_sign"}, sign_ctrl, e.sgn);
            check({tag, "_exec_wbv"}, wb_valid, 0);
            alu_zero     = z;
            alu_overflow = ov;
            @(negedge clk);                   // cycle 3: WB
            alu_zero     = 1'($urandom);
            alu_overflow = 1'($urandom);
            exp_trap = e.trp && ov;
            check({tag, "_wbv"}, wb_valid, 1);
            check({tag, "_trap"}, trap, exp_trap);
            check({tag, "_wr"}, reg_write, e.wr && !exp_trap);
            check({tag, "_br"}, branch_taken, e.br && z);
            if (e.wr) check({tag, "_wbreg"}, wb_reg, e.dst);
            check({tag, "_wb_op"}, alu_op, e.op);
            @(negedge clk);                   // cycle 4: IDLE
            check({tag, "_idle_wbv"}, wb_valid, 0);
            check({tag, "_idle_ready"}, instr_ready, 1);
            check({tag, "_idle_op_hold"}, alu_op, e.op);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int          acc_cnt;
        int          last_acc;

        for (int i = 0; i < 64; i++) begin
            r_op[i] = -1; i_op[i] = -1; i_srcb[i] = -1;
        end
        r_op[6'h20] = 0;  r_op[6'h21] = 0;  r_op[6'h22] = 1;  r_op[6'h23] = 1;
        r_op[6'h24] = 2;  r_op[6'h25] = 3;  r_op[6'h26] = 4;  r_op[6'h27] = 6;
        r_op[6'h2A] = 10; r_op[6'h2B] = 10; r_op[6'h00] = 12; r_op[6'h02] = 13;
        r_op[6'h03] = 9;
        i_op[4] = 1;  i_op[5] = 14; i_op[6] = 8;  i_op[7] = 11;
        i_op[8] = 0;  i_op[9] = 0;  i_op[10] = 10; i_op[11] = 10;
        i_op[12] = 2; i_op[13] = 3; i_op[14] = 4;
        i_srcb[4] = 0;  i_srcb[5] = 0;  i_srcb[6] = 3;  i_srcb[7] = 3;
        i_srcb[8] = 1;  i_srcb[9] = 1;  i_srcb[10] = 1; i_srcb[11] = 1;
        i_srcb[12] = 2; i_srcb[13] = 2; i_srcb[14] = 2;

        rst_n        = 1'b1;
        instr_valid  = 1'b0;
        instr        = '0;
        alu_zero     = 1'b0;
        alu_overflow = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", instr_ready, 0);
        check("rst_wbv", wb_valid, 0);
        check("rst_outs", {alu_op, sign_ctrl, alu_src_a, alu_src_b, reg_write, wb_reg, branch_taken, trap}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", instr_ready, 1);

        // Directed cases
        run_instr({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 1'b0, 1'b0, "add");
        run_instr({6'h08, 5'd1, 5'd5, 16'h8001}, 1'b0, 1'b1, "addi_ovf");
        run_instr({6'h09, 5'd1, 5'd5, 16'h8001}, 1'b0, 1'b1, "addiu_ovf");
        run_instr({6'h00, 5'd4, 5'd6, 5'd9, 5'd0, 6'h22}, 1'b0, 1'b1, "sub_ovf");
        run_instr({6'h05, 5'd1, 5'd2, 16'h0010}, 1'b1, 1'b0, "bne");
        run_instr({6'h06, 5'd1, 5'd0, 16'h0020}, 1'b0, 1'b0, "blez");
        run_instr({6'h00, 5'd0, 5'd2, 5'd7, 5'd4, 6'h03}, 1'b0, 1'b0, "sra");
        run_instr({6'h0B, 5'd3, 5'd8, 16'hFFF0}, 1'b0, 1'b0, "sltiu");
        run_instr({6'h3F, 26'h155_5555}, 1'b0, 1'b0, "illegal");

        // Randomized instructions
        for (int n = 0; n < 200; n++) begin
            w = $urandom;
            case ($urandom_range(0, 3))
                0: w = {6'h00, w[25:6], 6'(legal_fn[$urandom_range(0, 12)])};
                1: w = {6'h00, w[25:0]};
                2: w = {6'(legal_opc[$urandom_range(0, 10)]), w[25:0]};
                default: ;
            endcase
            run_instr(w, 1'($urandom), 1'($urandom), "rnd");
        end

        // instr_valid held high: accepts every 4 cycles, wb_valid on the 4th
        instr        = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
        instr_valid  = 1'b1;
        alu_zero     = 1'b0;
        alu_overflow = 1'b0;
        acc_cnt  = 0;
        last_acc = -1;
        for (int k = 0; k < 20; k++) begin
            if (instr_ready) begin
                if (last_acc >= 0) check("b2b_spacing", k - last_acc, 4);
                last_acc = k;
                acc_cnt++;
            end
            check("b2b_wbv", wb_valid, (k % 4) == 3);
            if (k == 19) instr_valid = 1'b0;
            @(negedge clk);
        end
        check("b2b_count", acc_cnt, 5);

        // Reset while in EXEC drops the instruction
        check("rstx_ready_pre", instr_ready, 1);
        instr       = {6'h06, 5'd1, 5'd0, 16'h0004};
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        check("rstx_op_pre", alu_op, 4'b1000);
        rst_n = 1'b0;
        #1;
        check("rstx_op", alu_op, 0);
        check("rstx_srcb", alu_src_b, 0);
        check("rstx_ready", instr_ready, 0);
        check("rstx_wbv", wb_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstx_ready_rel", instr_ready, 1);
        for (int k = 0; k < 5; k++) begin
            check("rstx_no_wbv", wb_valid, 0);
            @(negedge clk);
        end

        run_instr({6'h0A, 5'd3, 5'd9, 16'h7FFF}, 1'b0, 1'b0, "slti_post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
